// File: rtl/hs_elastic_buffer.sv
// hs_elastic_buffer: DEPTH-entry registered valid/ready elastic buffer.
// Every output comes from flops; no combinational ready or valid pass-through.
// Optional synchronous flush port enabled by defining HS_ELASTIC_FLUSH_EN.
module hs_elastic_buffer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned AFULL_TH = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         valid_pre_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic                         ready_pre_o,
  output logic                         valid_post_o,
  output logic [DATA_W-1:0]            data_o,
  input  logic                         ready_post_i,
`ifdef HS_ELASTIC_FLUSH_EN
  input  logic                         flush_i,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         afull_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic              ready_q,  ready_d;
  logic              valid_q,  valid_d;
  logic              afull_q,  afull_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic push;
  logic pop;
  logic flush;

`ifdef HS_ELASTIC_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Handshakes only use registered ready/valid, so data_i and ready_post_i are
  // don't-care whenever they cannot complete a transfer.
  assign push = valid_pre_i & ready_q;
  assign pop  = valid_q & ready_post_i;

  // Next-state computation for pointers, occupancy, status flags and storage.
  always_comb begin
    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      // Flush discards both handshakes of this cycle and empties the buffer.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
    // Status flags are registered from the next count so the outputs are flops.
    // A full buffer stays not-ready for one cycle even if it pops meanwhile.
    ready_d = (count_d != CNT_W'(DEPTH));
    valid_d = (count_d != '0);
    afull_d = (count_d >= CNT_W'(AFULL_TH));
  end

  // State registers; reset is asynchronous and asserted high.
  always_ff @(posedge clk or posedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
    if (reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      afull_q  <= afull_d;
    end
  end

  // Payload storage; cleared on reset so data_o reads 0 out of reset.
  always_ff @(posedge clk or posedge reset_n) begin
    // NOTE: storage is reset deliberately so the head payload is defined (0) right after reset.
    if (reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign ready_pre_o  = ready_q;
  assign valid_post_o = valid_q;
  assign data_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign afull_o      = afull_q;

endmodule

// File: tb/tb_hs_elastic_buffer.sv
// Directed testbench for hs_elastic_buffer: reset, stream, back-pressure,
// full-with-pop, mid-operation reset, random stress on DEPTH 2/4/16 and,
// when HS_ELASTIC_FLUSH_EN is defined, flush.
module tb_hs_elastic_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       valid_pre_i = 1'b0;
  logic [7:0] data_i = '0;
  logic       ready_pre_o;
  logic       valid_post_o;
  logic [7:0] data_o;
  logic       ready_post_i = 1'b0;
  logic [2:0] count_o;
  logic       afull_o;
  logic       flush_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hs_elastic_buffer #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3)) dut (
    .clk(clk), .reset_n(reset_n), .valid_pre_i(valid_pre_i), .data_i(data_i),
    .ready_pre_o(ready_pre_o), .valid_post_o(valid_post_o), .data_o(data_o),
    .ready_post_i(ready_post_i),
`ifdef HS_ELASTIC_FLUSH_EN
    .flush_i(flush_i),
`endif
    .count_o(count_o), .afull_o(afull_o));

  // Stress instances: index 0 -> DEPTH 2, 1 -> DEPTH 4, 2 -> DEPTH 16.
  logic       s_valid [3];
  logic [7:0] s_data  [3];
  logic       s_rdy   [3];
  logic       s_vout  [3];
  logic [7:0] s_dout  [3];
  logic       s_ready [3];
  logic       s_afull [3];
  logic [1:0] s2_cnt;
  logic [2:0] s4_cnt;
  logic [4:0] s16_cnt;
  int         s_cnt [3];
  int         s_th  [3];

  assign s_cnt[0] = int'(s2_cnt);
  assign s_cnt[1] = int'(s4_cnt);
  assign s_cnt[2] = int'(s16_cnt);

  hs_elastic_buffer #(.DATA_W(8), .DEPTH(2), .AFULL_TH(2)) u_s2 (
    .clk(clk), .reset_n(reset_n), .valid_pre_i(s_valid[0]), .data_i(s_data[0]),
    .ready_pre_o(s_rdy[0]), .valid_post_o(s_vout[0]), .data_o(s_dout[0]),
    .ready_post_i(s_ready[0]),
`ifdef HS_ELASTIC_FLUSH_EN
    .flush_i(1'b0),
`endif
    .count_o(s2_cnt), .afull_o(s_afull[0]));

  hs_elastic_buffer #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3)) u_s4 (
    .clk(clk), .reset_n(reset_n), .valid_pre_i(s_valid[1]), .data_i(s_data[1]),
    .ready_pre_o(s_rdy[1]), .valid_post_o(s_vout[1]), .data_o(s_dout[1]),
    .ready_post_i(s_ready[1]),
`ifdef HS_ELASTIC_FLUSH_EN
    .flush_i(1'b0),
`endif
    .count_o(s4_cnt), .afull_o(s_afull[1]));

  hs_elastic_buffer #(.DATA_W(8), .DEPTH(16), .AFULL_TH(12)) u_s16 (
    .clk(clk), .reset_n(reset_n), .valid_pre_i(s_valid[2]), .data_i(s_data[2]),
    .ready_pre_o(s_rdy[2]), .valid_post_o(s_vout[2]), .data_o(s_dout[2]),
    .ready_post_i(s_ready[2]),
`ifdef HS_ELASTIC_FLUSH_EN
    .flush_i(1'b0),
`endif
    .count_o(s16_cnt), .afull_o(s_afull[2]));

  // Advance to one time unit after the next rising edge (sampling/driving point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    vectors++; if (count_o !== 3'd0)     begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    vectors++; if (valid_post_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid_post_o); end
    vectors++; if (ready_pre_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", ready_pre_o); end
    vectors++; if (afull_o !== 1'b0)     begin miscompares++; $display("FAIL reset_afull: got %b expected 0", afull_o); end
    vectors++; if (data_o !== 8'h00)     begin miscompares++; $display("FAIL reset_data: got %0h expected 0", data_o); end
    reset_n = 1'b0;
    #1;
    vectors++; if (ready_pre_o !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge: got %b expected 0", ready_pre_o); end
    step();
    vectors++; if (ready_pre_o !== 1'b1) begin miscompares++; $display("FAIL ready_after_release: got %b expected 1", ready_pre_o); end
  endtask

  task automatic test_stream();
    valid_pre_i = 1'b1; ready_post_i = 1'b1; data_i = 8'd1;
    for (int k = 1; k <= 200; k++) begin
      step();
      vectors++; if (valid_post_o !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, valid_post_o); end
      vectors++; if (data_o !== 8'(k))      begin miscompares++; $display("FAIL stream_data[%0d]: got %0d expected %0d", k, data_o, k); end
      vectors++; if (count_o !== 3'd1)      begin miscompares++; $display("FAIL stream_count[%0d]: got %0d expected 1", k, count_o); end
      if (k < 200) data_i = 8'(k + 1);
      else valid_pre_i = 1'b0;
    end
    step();
    vectors++; if (count_o !== 3'd0 || valid_post_o !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got count %0d valid %b expected 0 0", count_o, valid_post_o); end
    ready_post_i = 1'b0;
  endtask

  task automatic test_backpressure();
    ready_post_i = 1'b0; valid_pre_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      data_i = 8'(k);
      step();
      vectors++; if (count_o !== 3'(k))         begin miscompares++; $display("FAIL fill_count[%0d]: got %0d expected %0d", k, count_o, k); end
      vectors++; if (afull_o !== (k >= 3))      begin miscompares++; $display("FAIL fill_afull[%0d]: got %b expected %b", k, afull_o, (k >= 3)); end
      vectors++; if (ready_pre_o !== (k != 4))  begin miscompares++; $display("FAIL fill_ready[%0d]: got %b expected %b", k, ready_pre_o, (k != 4)); end
      vectors++; if (data_o !== 8'd1)           begin miscompares++; $display("FAIL fill_head[%0d]: got %0d expected 1", k, data_o); end
    end
    data_i = 8'd5;
    step();
    vectors++; if (count_o !== 3'd4)     begin miscompares++; $display("FAIL fifth_rejected: got count %0d expected 4", count_o); end
    vectors++; if (data_o !== 8'd1 || valid_post_o !== 1'b1) begin miscompares++; $display("FAIL head_stable: got %0d/%b expected 1/1", data_o, valid_post_o); end
  endtask

  task automatic test_full_pop();
    logic [7:0] exp_head [5];
    int         exp_cnt  [5];
    exp_head = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    exp_cnt  = '{3, 3, 2, 1, 0};
    ready_post_i = 1'b1;                    // valid_pre_i still 1 with data 5
    vectors++; if (ready_pre_o !== 1'b0) begin miscompares++; $display("FAIL full_ready_low: got %b expected 0", ready_pre_o); end
    step();
    vectors++; if (ready_pre_o !== 1'b1) begin miscompares++; $display("FAIL full_ready_next: got %b expected 1", ready_pre_o); end
    vectors++; if (data_o !== exp_head[0] || count_o !== 3'(exp_cnt[0])) begin miscompares++; $display("FAIL full_pop0: got %0d/%0d expected %0d/%0d", data_o, count_o, exp_head[0], exp_cnt[0]); end
    for (int k = 1; k < 5; k++) begin
      step();
      if (k == 1) valid_pre_i = 1'b0;       // 5 accepted at this edge
      vectors++; if (count_o !== 3'(exp_cnt[k])) begin miscompares++; $display("FAIL full_count[%0d]: got %0d expected %0d", k, count_o, exp_cnt[k]); end
      if (exp_cnt[k] != 0) begin
        vectors++; if (data_o !== exp_head[k]) begin miscompares++; $display("FAIL full_order[%0d]: got %0d expected %0d", k, data_o, exp_head[k]); end
      end
    end
    ready_post_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    valid_pre_i = 1'b1; ready_post_i = 1'b0;
    for (int k = 0; k < 3; k++) begin data_i = 8'(10 + k); step(); end
    valid_pre_i = 1'b0;
    vectors++; if (count_o !== 3'd3) begin miscompares++; $display("FAIL mid_prefill: got %0d expected 3", count_o); end
    reset_n = 1'b1;
    #1;
    vectors++; if (count_o !== 3'd0 || valid_post_o !== 1'b0) begin miscompares++; $display("FAIL mid_reset_async: got %0d/%b expected 0/0", count_o, valid_post_o); end
    vectors++; if (ready_pre_o !== 1'b0) begin miscompares++; $display("FAIL mid_reset_ready: got %b expected 0", ready_pre_o); end
    step(); step();
    reset_n = 1'b0;
    #1;
    vectors++; if (ready_pre_o !== 1'b0) begin miscompares++; $display("FAIL mid_release_ready: got %b expected 0", ready_pre_o); end
    step();
    vectors++; if (ready_pre_o !== 1'b1) begin miscompares++; $display("FAIL mid_ready_edge: got %b expected 1", ready_pre_o); end
    valid_pre_i = 1'b1; data_i = 8'd20;
    step();
    valid_pre_i = 1'b0; ready_post_i = 1'b1;
    vectors++; if (data_o !== 8'd20 || count_o !== 3'd1) begin miscompares++; $display("FAIL mid_next_beat: got %0d/%0d expected 20/1", data_o, count_o); end
    step();
    ready_post_i = 1'b0;
    vectors++; if (count_o !== 3'd0) begin miscompares++; $display("FAIL mid_drain: got %0d expected 0", count_o); end
  endtask

`ifdef HS_ELASTIC_FLUSH_EN
  task automatic test_flush();
    valid_pre_i = 1'b1; ready_post_i = 1'b0;
    data_i = 8'd7; step();
    data_i = 8'd8; step();
    flush_i = 1'b1; data_i = 8'd9; ready_post_i = 1'b1;
    step();
    flush_i = 1'b0; valid_pre_i = 1'b0;
    vectors++; if (count_o !== 3'd0 || valid_post_o !== 1'b0) begin miscompares++; $display("FAIL flush_clear: got %0d/%b expected 0/0", count_o, valid_post_o); end
    vectors++; if (ready_pre_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b expected 1", ready_pre_o); end
    step();
    vectors++; if (valid_post_o !== 1'b0) begin miscompares++; $display("FAIL flush_no9: got valid %b data %0d expected 0", valid_post_o, data_o); end
    valid_pre_i = 1'b1; data_i = 8'd30;
    step();
    valid_pre_i = 1'b0;
    vectors++; if (data_o !== 8'd30) begin miscompares++; $display("FAIL flush_next: got %0d expected 30", data_o); end
    step();
    ready_post_i = 1'b0;
  endtask
`endif

  task automatic test_random_stress();
    int mq [3][$];
    int sent [3];
    int got  [3];
    int cyc;
    s_th = '{2, 3, 12};
    for (int i = 0; i < 3; i++) begin
      sent[i] = 0; got[i] = 0;
      s_valid[i] = 1'($urandom_range(0, 1)); s_data[i] = 8'd1;
      s_ready[i] = 1'($urandom_range(0, 1));
    end
    cyc = 0;
    while ((got[0] < 200 || got[1] < 200 || got[2] < 200) && cyc < 5000) begin
      for (int i = 0; i < 3; i++) begin
        if (s_cnt[i] != mq[i].size()) begin
          vectors++; miscompares++;
          $display("FAIL stress_count[%0d]: got %0d expected %0d", i, s_cnt[i], mq[i].size());
        end
        vectors++;
        if (s_afull[i] !== (mq[i].size() >= s_th[i])) begin
          miscompares++; $display("FAIL stress_afull[%0d]: got %b expected %b", i, s_afull[i], (mq[i].size() >= s_th[i]));
        end
        if (s_vout[i] && s_ready[i]) begin
          vectors++;
          if (mq[i].size() == 0 || s_dout[i] !== 8'(mq[i][0])) begin
            miscompares++; $display("FAIL stress_data[%0d]: got %0d expected %0d", i, s_dout[i], (mq[i].size() == 0) ? -1 : mq[i][0]);
          end
          if (mq[i].size() != 0) void'(mq[i].pop_front());
          got[i]++;
        end
        if (s_valid[i] && s_rdy[i]) begin
          mq[i].push_back(int'(s_data[i]));
          sent[i]++;
        end
      end
      step();
      cyc++;
      for (int i = 0; i < 3; i++) begin
        s_data[i]  = 8'(sent[i] + 1);
        s_valid[i] = (sent[i] < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_ready[i] = 1'($urandom_range(0, 1));
      end
    end
    vectors++;
    if (cyc >= 5000) begin
      miscompares++; $display("FAIL stress_timeout: got %0d/%0d/%0d beats expected 200 each", got[0], got[1], got[2]);
    end
    for (int i = 0; i < 3; i++) begin s_valid[i] = 1'b0; s_ready[i] = 1'b0; end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      s_valid[i] = 1'b0; s_data[i] = '0; s_ready[i] = 1'b0;
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
`ifdef HS_ELASTIC_FLUSH_EN
    test_flush();
`endif
    test_random_stress();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
